// File: rtl/instr_cache_pkg.sv
// Purpose: geometry constants, FSM encoding and block helpers for the instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ADDR_BITS/INDEX_BITS/TAG_BITS, WORDS_PER_BLOCK, BLOCK_BITS,
//   icache_state_t (IDLE=0, MEM_READ=1, UPDATE=2), block_word().
package instr_cache_pkg;

  localparam int ADDR_BITS       = 10;
  localparam int INDEX_BITS      = 3;
  localparam int OFFSET_BITS     = 4;  // 16-byte blocks
  localparam int TAG_BITS        = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_BITS      = 128;
  localparam int NUM_LINES       = 2 ** INDEX_BITS;
  localparam int BLK_ADDR_BITS   = ADDR_BITS - OFFSET_BITS;  // {tag,index}

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } icache_state_t;

  // Word 0 sits in bits [31:0], word 3 in [127:96].
  function automatic logic [31:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                             input logic [1:0] off);
    return blk[{off, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Purpose: bundles the CPU fetch port and the instruction-memory block port.
// Latency: n/a (wires only).
// Backpressure: busywait stalls the CPU; mem_busywait stalls the cache.
// Modports: slave = cache side, master = CPU + memory side.
interface instr_cache_if
  import instr_cache_pkg::*;
  ();

  logic [31:0]              pc;
  logic [31:0]              instruction;
  logic                     busywait;
  logic                     mem_read;
  logic [BLK_ADDR_BITS-1:0] mem_address;
  logic [BLOCK_BITS-1:0]    mem_readdata;
  logic                     mem_busywait;

  modport slave (
    input  pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );

endinterface

// File: rtl/instr_cache_line_store.sv
// Purpose: valid/tag/data arrays of the direct-mapped cache.
// Latency: read port combinational, write port takes effect at the next posedge.
// Backpressure: none; always accepts a write.
// Ports: rd_index -> rd_valid/rd_tag/rd_data; wr_en/wr_index/wr_tag/wr_data.
//   Valid bits clear asynchronously on rst_n=0; tags and data are never cleared.
module icache_line_store
  import instr_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Purpose: direct-mapped read-only instruction cache between CPU fetch and block memory.
// Latency: hit 0 cycles; miss N+2 stall cycles after the miss edge (N = memory busy cycles).
// Backpressure: busywait holds the CPU on a miss; mem_busywait holds the fill in MEM_READ.
// Ports: clk, rst_n (async, active low), bus (instr_cache_if.slave).
module instr_cache
  import instr_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  instr_cache_if.slave  bus
);

  logic [1:0]               pc_offset;
  logic [INDEX_BITS-1:0]    pc_index;
  logic [TAG_BITS-1:0]      pc_tag;
  logic                     unused_pc_bits;

  logic                     line_valid;
  logic [TAG_BITS-1:0]      line_tag;
  logic [BLOCK_BITS-1:0]    line_data;
  logic                     hit;

  icache_state_t            state_q, state_d;
  logic [BLK_ADDR_BITS-1:0] fill_addr_q;
  logic [BLOCK_BITS-1:0]    stage_q;
  logic                     busywait_c;
  logic                     mem_read_c;
  logic                     wr_en;

  // PC bits above ADDR_BITS alias; byte lane bits are don't-care.
  assign pc_offset      = bus.pc[3:2];
  assign pc_index       = bus.pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign pc_tag         = bus.pc[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];
  assign unused_pc_bits = ^{bus.pc[31:ADDR_BITS], bus.pc[1:0]};

  icache_line_store u_line_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_index (fill_addr_q[INDEX_BITS-1:0]),
    .wr_tag   (fill_addr_q[BLK_ADDR_BITS-1:INDEX_BITS]),
    .wr_data  (stage_q)
  );

  assign hit = line_valid && (line_tag == pc_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
    end else begin
      state_q <= state_d;
      // Latch the fill address once so a misbehaving PC cannot retarget the fill.
      if (state_q == IDLE && !hit) begin
        fill_addr_q <= {pc_tag, pc_index};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == MEM_READ && !bus.mem_busywait) begin
      stage_q <= bus.mem_readdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    busywait_c = 1'b0;
    mem_read_c = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        busywait_c = !hit;
        if (!hit) state_d = MEM_READ;
      end
      MEM_READ: begin
        busywait_c = 1'b1;
        mem_read_c = 1'b1;
        if (!bus.mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait_c = 1'b1;
        wr_en      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In reset every line reads as a miss; gating keeps busywait low while held.
  assign bus.busywait    = busywait_c && rst_n;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_address = fill_addr_q;
  assign bus.instruction = hit ? block_word(line_data, pc_offset) : 32'h0;

endmodule

// File: tb/tb_instr_cache.sv
// Purpose: scoreboard bench for instr_cache with a variable-latency block memory model.
// Latency: memory model holds mem_busywait for `latency` cycles of each read.
// Backpressure: driver holds PC until the monitor retires the current fetch.
module tb_instr_cache;
  import instr_cache_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          bw;
    bit          rd;
    logic [5:0]  addr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   latency;
  int   lat_cnt;
  int   checks;
  int   errors;
  int   issued;
  int   pops;
  bit   mon_en;
  exp_t q[$];

  instr_cache_if bus();

  instr_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: word at byte address A holds A>>2, so block B = {4B+3,4B+2,4B+1,4B}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lat_cnt <= 0;
    else if (bus.mem_read) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  assign bus.mem_busywait = bus.mem_read && (lat_cnt < latency);

  always_comb begin
    bus.mem_readdata = {4{32'hDEAD_BEEF}};
    if (bus.mem_read) begin
      for (int w = 0; w < 4; w++) begin
        bus.mem_readdata[w*32 +: 32] = {24'b0, bus.mem_address, 2'(w)};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles and memory activity, retires on busywait=0.
  initial begin : monitor
    int   bw_cnt;
    bit   saw_rd;
    logic [5:0] seen_addr;
    exp_t e;
    bw_cnt    = 0;
    saw_rd    = 0;
    seen_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en || q.size() == 0) begin
        bw_cnt = 0;
        saw_rd = 0;
      end else begin
        if (bus.mem_read) begin
          if (!saw_rd) seen_addr = bus.mem_address;
          saw_rd = 1;
        end
        if (bus.busywait) begin
          bw_cnt++;
        end else begin
          e = q.pop_front();
          chk($sformatf("instr@%h", e.pc), bus.instruction, e.instr);
          chk($sformatf("stall@%h", e.pc), 32'(bw_cnt), 32'(e.bw));
          chk($sformatf("mem_read@%h", e.pc), 32'(saw_rd), 32'(e.rd));
          if (e.rd && saw_rd) chk($sformatf("mem_addr@%h", e.pc), 32'(seen_addr), 32'(e.addr));
          pops++;
          bw_cnt = 0;
          saw_rd = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input bit miss,
                       input logic [5:0] addr, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.bw    = miss ? latency + 2 : 0;
    e.rd    = miss;
    e.addr  = addr;
    q.push_back(e);
    issued++;
    bus.pc = pc;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #2;
      if (pops == issued) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: pc=%h retired %0d of %0d", bus.pc, pops, issued);
    q.delete();
    issued = pops;
  endtask

  task automatic fetch(input logic [31:0] pc, input bit miss,
                       input logic [5:0] addr, input logic [31:0] instr);
    issue(pc, miss, addr, instr);
    wait_done();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got_rd;
    checks  = 0;
    errors  = 0;
    issued  = 0;
    pops    = 0;
    mon_en  = 0;
    latency = 5;
    rst_n   = 1'b0;
    bus.pc  = 32'h0;

    // Outputs while reset is held, even though PC misses.
    repeat (2) @(posedge clk);
    #2;
    chk("rst busywait", 32'(bus.busywait), 32'h0);
    chk("rst mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst mem_addr", 32'(bus.mem_address), 32'h0);
    chk("rst instr", bus.instruction, 32'h0);

    // Cold miss: queued before release because the fill starts at the first edge.
    issue(32'h000, 1, 6'h00, 32'h0000_0000);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    wait_done();

    // Same-block hits in consecutive cycles.
    fetch(32'h004, 0, 6'h00, 32'h0000_0001);
    fetch(32'h008, 0, 6'h00, 32'h0000_0002);
    fetch(32'h00C, 0, 6'h00, 32'h0000_0003);

    // Conflict eviction on index 0.
    fetch(32'h080, 1, 6'h08, 32'h0000_0020);
    fetch(32'h000, 1, 6'h00, 32'h0000_0000);

    // Last index, top of space, and an alias above ADDR_BITS.
    fetch(32'h070, 1, 6'h07, 32'h0000_001C);
    fetch(32'h3FC, 1, 6'h3F, 32'h0000_00FF);
    fetch(32'h0000_07FC, 0, 6'h3F, 32'h0000_00FF);

    // Reset two cycles into a fill.
    mon_en = 0;
    bus.pc = 32'h010;
    got_rd = 0;
    for (int k = 0; k < 10 && !got_rd; k++) begin
      @(posedge clk);
      #2;
      got_rd = bus.mem_read;
    end
    chk("midfill mem_read seen", 32'(got_rd), 32'h1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfill mem_read", 32'(bus.mem_read), 32'h0);
    chk("midfill busywait", 32'(bus.busywait), 32'h0);
    chk("midfill instr", bus.instruction, 32'h0);
    issue(32'h010, 1, 6'h01, 32'h0000_0004);
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    wait_done();

    // Zero-latency memory.
    latency = 0;
    fetch(32'h020, 1, 6'h02, 32'h0000_0008);
    fetch(32'h024, 0, 6'h02, 32'h0000_0009);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
